// File: rtl/pipe_pkg.sv
// Shared types and default sizing for the MEM/WB skid-buffered pipeline stage.
package pipe_pkg;

  // Payload width: WB + DM + ADD + Rd bundle of the MEM/WB stage.
  localparam int DATA_W_DEF = 71;
  // Width of the back-pressure (stall) cycle counter.
  localparam int CNT_W_DEF  = 16;

  // Occupancy of the two-entry stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no entries held
    BUSY  = 2'd1,  // main entry only
    FULL  = 2'd2   // main + skid entries
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with i_inc high and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count up on i_inc, hold once every bit is set; reset clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register for the MEM/WB stage.
// in_ready comes straight from a flop so the upstream stage never sees a
// combinational path from out_ready; the skid entry absorbs the one beat
// that can arrive in the cycle downstream stalls.
//
// state | meaning
// EMPTY | nothing held, out_valid low, in_ready high
// BUSY  | main holds the head beat, in_ready high
// FULL  | main + skid both hold beats, in_ready low
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              r_in_ready;
  logic              w_out_valid;
  logic              w_stall;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush forces EMPTY regardless of handshakes.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (in_valid) w_state_nxt = BUSY;
        BUSY: begin
          if (in_valid && !out_ready)      w_state_nxt = FULL;
          else if (!in_valid && out_ready) w_state_nxt = EMPTY;
        end
        FULL:  if (out_ready) w_state_nxt = BUSY;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // Outputs decoded from state; payload is forced to zero when not valid.
  always_comb begin
    w_out_valid = (r_state == BUSY) || (r_state == FULL);
    w_stall     = w_out_valid && !out_ready;
    out_data    = w_out_valid ? r_main : '0;
  end

  // in_ready is registered from the next state so it only changes at an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= (w_state_nxt != FULL);
    end
  end

  // Entry datapath: load main/skid on accepted beats, promote skid on drain.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      case (r_state)
        EMPTY: if (in_valid) r_main <= in_data;
        BUSY: begin
          if (in_valid && out_ready)       r_main <= in_data;
          else if (in_valid && !out_ready) r_skid <= in_data;
        end
        FULL:  if (out_ready) r_main <= r_skid;
        default: ;
      endcase
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_stall),
    .o_cnt (stall_cnt)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 71, payload width (WB + DM + ADD + Rd bundle of the MEM/WB stage).
REQ-002 Parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  discard all held entries (bubble insertion).
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  stage can accept a beat this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 out_valid  output  1  downstream beat present.
REQ-010 out_ready  input  1  downstream accepts this cycle.
REQ-011 out_data  output  DATA_W  downstream payload.
REQ-012 stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

Function
REQ-013 A beat SHALL transfer in at a rising edge where in_valid && in_ready, and out where out_valid && out_ready.
REQ-014 The block SHALL hold two entries, main (drives out_data) and skid, tracked by states EMPTY, BUSY (main only) and FULL (main + skid).
REQ-015 in_ready SHALL be a registered signal equal to 1 in EMPTY and BUSY, 0 in FULL; it SHALL NOT depend combinationally on out_ready.
REQ-016 out_valid SHALL be 1 in BUSY and FULL, 0 in EMPTY.
REQ-017 EMPTY: in_valid -> BUSY, main <= in_data; else stay.
REQ-018 BUSY: in_valid && out_ready -> BUSY, main <= in_data; in_valid && !out_ready -> FULL, skid <= in_data; !in_valid && out_ready -> EMPTY; else stay.
REQ-019 FULL: out_ready -> BUSY, main <= skid; else stay, all entries unchanged.
REQ-020 Latency from accepted input beat to out_valid SHALL be exactly one cycle when the stage is EMPTY or draining; sustained throughput SHALL be one beat per cycle with out_ready held 1.
REQ-021 Beats SHALL leave in acceptance order, each exactly once, with no loss or duplication.
REQ-022 flush SHALL take priority over all transitions: next state EMPTY, main and skid cleared to zero, any in beat in the same cycle dropped; an out handshake in the same cycle counts as delivered.
REQ-023 While out_valid is 0, out_data SHALL be all zeros.
REQ-024 stall_cnt SHALL increment by 1 each cycle with out_valid && !out_ready, saturate at 2^CNT_W-1, and not be affected by flush.

Reset
REQ-025 When rst is 1 at a rising edge: state EMPTY, main = skid = 0, stall_cnt = 0; rst SHALL override flush and all handshakes.
REQ-026 In the first cycle after reset: in_ready = 1, out_valid = 0, out_data = 0, stall_cnt = 0.
REQ-027 Reset asserted mid-operation SHALL discard all held beats without emitting them.

Structure
REQ-028 A shared package pipe_pkg SHALL hold the state typedef (EMPTY, BUSY, FULL) and the default DATA_W and CNT_W constants.
REQ-029 The saturating counter SHALL be one sub-module, sat_counter, parametrised by CNT_W.

Verification
REQ-030 Reset then in_valid=1, in_data=0x5A every cycle, out_ready=1 -> out_valid=1 from cycle 2, out_data=0x5A each cycle, in_ready stays 1, stall_cnt=0.
REQ-031 Send beats 1,2,3 back-to-back with out_ready=0 from the cycle beat 2 arrives -> FULL after beat 2, in_ready=0, beat 3 held upstream; release out_ready -> outputs 1,2,3 in order, none lost.
REQ-032 FULL state, assert flush with in_valid=1 (beat 0x7) -> next cycle EMPTY, out_valid=0, out_data=0, in_ready=1, 0x7 never emitted.
REQ-033 CNT_W=4, out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds; flush leaves 15; rst clears to 0.
REQ-034 Random in_valid/out_ready (50% each, 10,000 cycles) against a scoreboard FIFO -> exact in-order match, in_ready never depends on same-cycle out_ready.
REQ-035 rst asserted in BUSY with flush=1 and in_valid=1 -> next cycle matches REQ-026 exactly.
